axi_mem_responder: RTL and testbench

Simulation/FPGA-side AXI responder that terminates the LSU's 64-bit load/store master port (AW/W/B/AR/R, single-beat, no IDs, no RESP). It owns a word-addressed 64-bit memory, accepts one outstanding write and one outstanding read, and returns B and R responses after a programmable latency. It sits at the far end of the core's data-memory AXI interface, in place of the external memory model.

---
 rtl/axi_mem_responder_if.sv | 40 ++++
 rtl/axi_mem_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// -----------------------------------------------------------------------------
// axi_mem_responder_if
// Single-beat AXI-style load/store bus between the LSU master and the memory
// responder. There are no IDs and no RESP fields.
//   aw_addr/aw_valid/aw_ready : write byte address channel
//   w_data/w_strb/w_valid/w_ready : write data channel (strb bit i -> byte i)
//   b_valid/b_ready : write completion
//   ar_addr/ar_valid/ar_ready : read byte address channel
//   r_data/r_valid/r_ready : read data
// Modports: master (LSU side) and slave (responder side).
// -----------------------------------------------------------------------------
interface axi_mem_responder_if;
  logic [63:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic        b_valid;
  logic        b_ready;
  logic [63:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] r_data;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_valid, ar_ready, r_data, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_valid, ar_ready, r_data, r_valid
  );
endinterface

// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
// Terminates the LSU's 64-bit single-beat AXI port with a word-addressed
// 64-bit memory. One outstanding write and one outstanding read; B and R are
// returned after a programmable latency. Read and write paths are independent.
//
// Parameters:
//   BASE   byte address of word 0
//   DEPTH  number of 64-bit words (power of two)
//   RD_LAT cycles from AR handshake to R valid (>= 1)
//   WR_LAT cycles from write capture complete to B valid (>= 1)
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset (memory contents are not reset)
//   axi    slave side of axi_mem_responder_if
// Optional feature:
//   AXI_MEM_RAND_DELAY_EN adds 0-3 extra wait cycles per transaction taken
//   from an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5).
// -----------------------------------------------------------------------------
module axi_mem_responder #(
  parameter logic [63:0] BASE   = 64'h8000_0000,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_mem_responder_if.slave    axi
);

  localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  typedef logic [15:0] cnt_t;
  localparam cnt_t RD_LOAD = cnt_t'(RD_LAT - 1);
  localparam cnt_t WR_LOAD = cnt_t'(WR_LAT - 1);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

  logic [63:0] mem [DEPTH];

  // extra wait cycles added on entry to either wait state
  cnt_t extra;
`ifdef AXI_MEM_RAND_DELAY_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign extra = cnt_t'(lfsr[1:0]);
`else
  assign extra = '0;
`endif

  // address decode; ADDR[2:0] drops out through the shift
  logic [63:0]   aw_off, ar_off;
  logic [IW-1:0] aw_idx, ar_idx;
  logic          aw_in, ar_in;
  assign aw_off = axi.aw_addr - BASE;
  assign ar_off = axi.ar_addr - BASE;
  assign aw_in  = aw_off < SPAN;
  assign ar_in  = ar_off < SPAN;
  assign aw_idx = IW'(aw_off >> 3);
  assign ar_idx = IW'(ar_off >> 3);

  // ---------------------------------------------------------------- write path
  wstate_t       wstate, wstate_nxt;
  cnt_t          wcnt, wcnt_nxt;
  logic          aw_rdy, w_rdy, b_vld;
  logic          aw_rdy_nxt, w_rdy_nxt, b_vld_nxt;
  logic          aw_got, w_got, aw_got_nxt, w_got_nxt;
  logic          aw_hs, w_hs, mem_we;
  logic [IW-1:0] wr_idx;
  logic          wr_in;
  logic [63:0]   wr_data;
  logic [7:0]    wr_strb;

  assign aw_hs = (wstate == W_IDLE) && aw_rdy && axi.aw_valid;
  assign w_hs  = (wstate == W_IDLE) && w_rdy && axi.w_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate <= W_IDLE;
      wcnt   <= '0;
      aw_rdy <= 1'b0;
      w_rdy  <= 1'b0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      b_vld  <= 1'b0;
    end else begin
      wstate <= wstate_nxt;
      wcnt   <= wcnt_nxt;
      aw_rdy <= aw_rdy_nxt;
      w_rdy  <= w_rdy_nxt;
      aw_got <= aw_got_nxt;
      w_got  <= w_got_nxt;
      b_vld  <= b_vld_nxt;
    end
  end

  always_comb begin
    wstate_nxt = wstate;
    unique case (wstate)
      W_IDLE:  if ((aw_got || aw_hs) && (w_got || w_hs)) wstate_nxt = W_WAIT;
      W_WAIT:  if (wcnt == '0) wstate_nxt = W_RESP;
      W_RESP:  if (axi.b_ready) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Each ready is the registered inverse of its own "captured" flag, so AW and
  // W drop independently and may arrive in either order or together.
  always_comb begin
    wcnt_nxt   = wcnt;
    aw_rdy_nxt = aw_rdy;
    w_rdy_nxt  = w_rdy;
    aw_got_nxt = aw_got;
    w_got_nxt  = w_got;
    b_vld_nxt  = b_vld;
    mem_we     = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        aw_got_nxt = aw_got || aw_hs;
        w_got_nxt  = w_got || w_hs;
        aw_rdy_nxt = !(aw_got || aw_hs);
        w_rdy_nxt  = !(w_got || w_hs);
        wcnt_nxt   = WR_LOAD + extra;
      end
      W_WAIT: begin
        if (wcnt == '0) begin
          mem_we    = wr_in;
          b_vld_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt - 1'b1;
        end
      end
      W_RESP: begin
        if (axi.b_ready) begin
          b_vld_nxt  = 1'b0;
          aw_rdy_nxt = 1'b1;
          w_rdy_nxt  = 1'b1;
          aw_got_nxt = 1'b0;
          w_got_nxt  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- read path
  rstate_t       rstate, rstate_nxt;
  cnt_t          rcnt, rcnt_nxt;
  logic          ar_rdy, r_vld, ar_rdy_nxt, r_vld_nxt;
  logic [63:0]   r_dat, r_dat_nxt;
  logic          ar_hs;
  logic [IW-1:0] rd_idx;
  logic          rd_in;

  assign ar_hs = (rstate == R_IDLE) && ar_rdy && axi.ar_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate <= R_IDLE;
      rcnt   <= '0;
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      r_dat  <= '0;
    end else begin
      rstate <= rstate_nxt;
      rcnt   <= rcnt_nxt;
      ar_rdy <= ar_rdy_nxt;
      r_vld  <= r_vld_nxt;
      r_dat  <= r_dat_nxt;
    end
  end

  always_comb begin
    rstate_nxt = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_WAIT;
      R_WAIT:  if (rcnt == '0) rstate_nxt = R_RESP;
      R_RESP:  if (axi.r_ready) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // The memory is sampled through its pre-edge value, so a write committing on
  // the same edge is not visible to this read.
  always_comb begin
    rcnt_nxt   = rcnt;
    ar_rdy_nxt = ar_rdy;
    r_vld_nxt  = r_vld;
    r_dat_nxt  = r_dat;
    unique case (rstate)
      R_IDLE: begin
        ar_rdy_nxt = !ar_hs;
        rcnt_nxt   = RD_LOAD + extra;
      end
      R_WAIT: begin
        if (rcnt == '0) begin
          r_vld_nxt = 1'b1;
          r_dat_nxt = rd_in ? mem[rd_idx] : '0;
        end else begin
          rcnt_nxt = rcnt - 1'b1;
        end
      end
      R_RESP: begin
        if (axi.r_ready) begin
          r_vld_nxt  = 1'b0;
          ar_rdy_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------- capture and storage
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      wr_idx <= aw_idx;
      wr_in  <= aw_in;
    end
    if (w_hs) begin
      wr_data <= axi.w_data;
      wr_strb <= axi.w_strb;
    end
    if (ar_hs) begin
      rd_idx <= ar_idx;
      rd_in  <= ar_in;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign axi.aw_ready = aw_rdy;
  assign axi.w_ready  = w_rdy;
  assign axi.b_valid  = b_vld;
  assign axi.ar_ready = ar_rdy;
  assign axi.r_valid  = r_vld;
  assign axi.r_data   = r_dat;

endmodule

// File: tb/tb_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_responder
// Self-checking bench for axi_mem_responder (default build, RD_LAT = WR_LAT = 2).
// A sparse word-indexed reference memory with strobe merging and range rules
// supplies every expected read value; latencies and handshake timing are
// checked against the parameter values.
// -----------------------------------------------------------------------------
module tb_axi_mem_responder;

  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_mem_responder_if m ();

  axi_mem_responder #(
    .BASE   (BASE),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi   (m)
  );

  // ------------------------------------------------------------ reference model
  logic [63:0] ref_mem [longint unsigned];

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < 64'(DEPTH) * 64'd8);
  endfunction

  function automatic longint unsigned word_of(input logic [63:0] a);
    return longint'((a - BASE) / 64'd8);
  endfunction

  function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] old, mask;
    if (!in_range(a)) return;
    old  = ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 'x;
    mask = '0;
    for (int i = 0; i < 8; i++) if (s[i]) mask = mask | (64'hFF << (8 * i));
    ref_mem[word_of(a)] = (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a);
    if (!in_range(a)) return 64'h0;
    return ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 'x;
  endfunction

  function automatic logic [63:0] rand_addr(input bit oor);
    logic [63:0] a;
    if (!oor)
      a = BASE + 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7));
    else if ($urandom_range(0, 1) == 0)
      a = BASE - 64'($urandom_range(1, 40)) * 64'd8;
    else
      a = BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 40)) * 64'd8 + 64'($urandom_range(0, 7));
    return a;
  endfunction

  // ---------------------------------------------------------------- bus drivers
  task automatic axi_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold,
                           output int lat, output int m_cyc, output int b_cyc, output bit stable,
                           output bit held_low, output logic [1:0] rdy_after, output bit ok);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    ok = 1; stable = 1; held_low = 1; lat = -1; m_cyc = 0; b_cyc = 0; rdy_after = '0;
    aw_done = 0; w_done = 0; n = 0;
    m.aw_addr = addr; m.w_data = data; m.w_strb = strb;
    while (!(aw_done && w_done)) begin
      m.aw_valid = !aw_done && (n >= aw_dly);
      m.w_valid  = !w_done && (n >= w_dly);
      aw_fire = m.aw_valid && m.aw_ready;
      w_fire  = m.w_valid && m.w_ready;
      @(posedge clk); #1; n++;
      aw_done |= aw_fire;
      w_done  |= w_fire;
      if (aw_done && !w_done && m.aw_ready !== 1'b0) held_low = 0;
      if (w_done && !aw_done && m.w_ready !== 1'b0) held_low = 0;
      if (n > 64) begin ok = 0; m.aw_valid = 0; m.w_valid = 0; return; end
    end
    m.aw_valid = 0; m.w_valid = 0;
    m_cyc = cyc;
    n = 0;
    while (m.b_valid !== 1'b1) begin
      @(posedge clk); #1;
      if (++n > 64) begin ok = 0; return; end
    end
    lat = cyc - m_cyc;
    for (int i = 0; i < b_hold; i++) begin
      @(posedge clk); #1;
      if (m.b_valid !== 1'b1) stable = 0;
    end
    m.b_ready = 1;
    @(posedge clk); #1;
    m.b_ready = 0;
    b_cyc = cyc;
    rdy_after = {m.aw_ready, m.w_ready};
  endtask

  task automatic axi_read(input logic [63:0] addr, input int ar_dly, input int r_hold,
                          output logic [63:0] data, output int lat, output int ar_cyc,
                          output int r_cyc, output bit stable, output bit ok);
    bit fire;
    int n;
    logic [63:0] first;
    ok = 1; stable = 1; data = '0; lat = -1; ar_cyc = 0; r_cyc = 0; n = 0;
    m.ar_addr = addr;
    forever begin
      m.ar_valid = (n >= ar_dly);
      fire = m.ar_valid && m.ar_ready;
      @(posedge clk); #1; n++;
      if (fire) break;
      if (n > 64) begin ok = 0; m.ar_valid = 0; return; end
    end
    m.ar_valid = 0;
    ar_cyc = cyc;
    n = 0;
    while (m.r_valid !== 1'b1) begin
      @(posedge clk); #1;
      if (++n > 64) begin ok = 0; return; end
    end
    lat = cyc - ar_cyc;
    first = m.r_data;
    for (int i = 0; i < r_hold; i++) begin
      @(posedge clk); #1;
      if (m.r_valid !== 1'b1 || m.r_data !== first) stable = 0;
    end
    m.r_ready = 1;
    @(posedge clk); #1;
    m.r_ready = 0;
    r_cyc = cyc;
    data = first;
  endtask

  // ------------------------------------------------------------------ scenarios
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({m.aw_ready, m.w_ready, m.ar_ready} !== 3'b000) begin n_bad++;
      $display("FAIL reset_readies: got %b want 000", {m.aw_ready, m.w_ready, m.ar_ready}); end
    n_cmp++; if ({m.b_valid, m.r_valid} !== 2'b00) begin n_bad++;
      $display("FAIL reset_valids: got %b want 00", {m.b_valid, m.r_valid}); end
    n_cmp++; if (m.r_data !== 64'h0) begin n_bad++;
      $display("FAIL reset_rdata: got %h want 0", m.r_data); end
    rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if ({m.aw_ready, m.w_ready, m.ar_ready} !== 3'b111) begin n_bad++;
      $display("FAIL reset_release_readies: got %b want 111", {m.aw_ready, m.w_ready, m.ar_ready}); end
  endtask

  task automatic test_init();
    int lat, mc, bc; bit st, hl, ok; logic [1:0] ra; logic [63:0] a, d;
    for (int w = 0; w < 17; w++) begin
      a = (w == 16) ? BASE + 64'(DEPTH - 1) * 64'd8 : BASE + 64'(w) * 64'd8;
      d = {$urandom(), $urandom()};
      axi_write(a, d, 8'hFF, 0, 0, 0, lat, mc, bc, st, hl, ra, ok);
      model_write(a, d, 8'hFF);
      n_cmp++; if (!ok || lat !== WR_LAT) begin n_bad++;
        $display("FAIL init_wr_lat w%0d: got %0d ok=%0b want %0d", w, lat, ok, WR_LAT); end
    end
  endtask

  task automatic test_write_read();
    int lat, mc, bc, ac, rc; bit st, hl, ok; logic [1:0] ra; logic [63:0] d;
    axi_write(64'h8000_0010, 64'h1122334455667788, 8'hFF, 0, 0, 0, lat, mc, bc, st, hl, ra, ok);
    model_write(64'h8000_0010, 64'h1122334455667788, 8'hFF);
    n_cmp++; if (!ok || lat !== WR_LAT) begin n_bad++;
      $display("FAIL wr_lat: got %0d ok=%0b want %0d", lat, ok, WR_LAT); end
    axi_read(64'h8000_0010, 0, 0, d, lat, ac, rc, st, ok);
    n_cmp++; if (!ok || lat !== RD_LAT) begin n_bad++;
      $display("FAIL rd_lat: got %0d ok=%0b want %0d", lat, ok, RD_LAT); end
    n_cmp++; if (d !== 64'h1122334455667788) begin n_bad++;
      $display("FAIL wr_rd_data: got %h want 1122334455667788", d); end
  endtask

  task automatic test_strobe_merge();
    int lat, mc, bc, ac, rc; bit st, hl, ok; logic [1:0] ra; logic [63:0] d, a;
    a = BASE + 64'd24;
    axi_write(a, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0, lat, mc, bc, st, hl, ra, ok);
    model_write(a, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    axi_write(a, 64'h0, 8'h0F, 0, 0, 0, lat, mc, bc, st, hl, ra, ok);
    model_write(a, 64'h0, 8'h0F);
    axi_read(a, 0, 0, d, lat, ac, rc, st, ok);
    n_cmp++; if (!ok || d !== 64'hFFFF_FFFF_0000_0000) begin n_bad++;
      $display("FAIL strobe_merge: got %h want ffffffff00000000", d); end
    axi_write(a, 64'h1234_5678_9ABC_DEF0, 8'h00, 0, 0, 0, lat, mc, bc, st, hl, ra, ok);
    model_write(a, 64'h1234_5678_9ABC_DEF0, 8'h00);
    n_cmp++; if (!ok || lat !== WR_LAT) begin n_bad++;
      $display("FAIL strobe_zero_b: got lat %0d ok=%0b want %0d", lat, ok, WR_LAT); end
    axi_read(a, 0, 0, d, lat, ac, rc, st, ok);
    n_cmp++; if (d !== model_read(a)) begin n_bad++;
      $display("FAIL strobe_zero_data: got %h want %h", d, model_read(a)); end
  endtask

  task automatic test_skew_backpressure();
    int lat, mc, bc, ac, rc; bit st, hl, ok; logic [1:0] ra; logic [63:0] d, a;
    a = BASE + 64'd32;
    axi_write(a, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 3, 0, 5, lat, mc, bc, st, hl, ra, ok);
    model_write(a, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
    n_cmp++; if (!ok || lat !== WR_LAT) begin n_bad++;
      $display("FAIL skew_lat: got %0d ok=%0b want %0d", lat, ok, WR_LAT); end
    n_cmp++; if (hl !== 1'b1) begin n_bad++;
      $display("FAIL skew_w_ready_low: got %0b want 1", hl); end
    n_cmp++; if (st !== 1'b1) begin n_bad++;
      $display("FAIL bp_b_stable: got %0b want 1", st); end
    n_cmp++; if (ra !== 2'b11) begin n_bad++;
      $display("FAIL bp_readies_after_b: got %b want 11", ra); end
    axi_read(a, 0, 4, d, lat, ac, rc, st, ok);
    n_cmp++; if (d !== model_read(a) || st !== 1'b1) begin n_bad++;
      $display("FAIL skew_readback: got %h stable=%0b want %h", d, st, model_read(a)); end
  endtask

  task automatic test_concurrent_oor();
    int wl, mc, bc, rl, ac, rc; bit wst, hl, wok, rst_ok, rst_st; logic [1:0] ra;
    logic [63:0] d, exp_r;
    exp_r = model_read(BASE + 64'd72);
    fork
      axi_write(BASE + 64'd56, 64'h0707_0707_0707_0707, 8'hFF, 0, 0, 0, wl, mc, bc, wst, hl, ra, wok);
      axi_read(BASE + 64'd72, 0, 0, d, rl, ac, rc, rst_st, rst_ok);
    join
    model_write(BASE + 64'd56, 64'h0707_0707_0707_0707, 8'hFF);
    n_cmp++; if (!wok || wl !== WR_LAT || !rst_ok || rl !== RD_LAT) begin n_bad++;
      $display("FAIL conc_lat: got wr %0d rd %0d want %0d %0d", wl, rl, WR_LAT, RD_LAT); end
    n_cmp++; if (d !== exp_r) begin n_bad++;
      $display("FAIL conc_rd_data: got %h want %h", d, exp_r); end
    axi_read(BASE + 64'd56, 0, 0, d, rl, ac, rc, rst_st, rst_ok);
    n_cmp++; if (d !== 64'h0707_0707_0707_0707) begin n_bad++;
      $display("FAIL conc_wr_data: got %h want 0707070707070707", d); end
    axi_read(64'h7FFF_FFF8, 0, 0, d, rl, ac, rc, rst_st, rst_ok);
    n_cmp++; if (!rst_ok || d !== 64'h0) begin n_bad++;
      $display("FAIL oor_read: got %h want 0", d); end
    // one past the last word: dropped, must not alias onto word 0
    axi_write(BASE + 64'(DEPTH) * 64'd8, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 0, 0, 0, wl, mc, bc, wst, hl, ra, wok);
    n_cmp++; if (!wok || wl !== WR_LAT) begin n_bad++;
      $display("FAIL oor_write_b: got lat %0d ok=%0b want %0d", wl, wok, WR_LAT); end
    axi_read(BASE, 0, 0, d, rl, ac, rc, rst_st, rst_ok);
    n_cmp++; if (d !== model_read(BASE)) begin n_bad++;
      $display("FAIL oor_write_dropped: got %h want %h", d, model_read(BASE)); end
    axi_read(BASE + 64'(DEPTH - 1) * 64'd8 + 64'd5, 0, 0, d, rl, ac, rc, rst_st, rst_ok);
    n_cmp++; if (d !== model_read(BASE + 64'(DEPTH - 1) * 64'd8)) begin n_bad++;
      $display("FAIL last_word_read: got %h want %h", d, model_read(BASE + 64'(DEPTH - 1) * 64'd8)); end
  endtask

  task automatic test_collision();
    int wl, mc, bc, rl, ac, rc; bit st, hl, ok, rok; logic [1:0] ra; logic [63:0] d, a;
    a = BASE + 64'd40;
    axi_write(a, 64'hB, 8'hFF, 0, 0, 0, wl, mc, bc, st, hl, ra, ok);
    model_write(a, 64'hB, 8'hFF);
    fork
      axi_write(a, 64'hA, 8'hFF, 0, 0, 0, wl, mc, bc, st, hl, ra, ok);
      axi_read(a, 0, 0, d, rl, ac, rc, st, rok);
    join
    model_write(a, 64'hA, 8'hFF);
    n_cmp++; if (mc + WR_LAT !== ac + RD_LAT) begin n_bad++;
      $display("FAIL coll_alignment: got commit edge %0d sample edge %0d want equal", mc + WR_LAT, ac + RD_LAT); end
    n_cmp++; if (!rok || d !== 64'hB) begin n_bad++;
      $display("FAIL coll_old_data: got %h want b", d); end
    axi_read(a, 0, 0, d, rl, ac, rc, st, rok);
    n_cmp++; if (d !== 64'hA) begin n_bad++;
      $display("FAIL coll_new_data: got %h want a", d); end
  endtask

  task automatic test_back_to_back();
    int l, mc1, bc1, mc2, bc2, ac1, rc1, ac2, rc2; bit st, hl, ok; logic [1:0] ra; logic [63:0] d;
    axi_read(BASE + 64'd8, 0, 0, d, l, ac1, rc1, st, ok);
    axi_read(BASE + 64'd16, 0, 0, d, l, ac2, rc2, st, ok);
    n_cmp++; if (ac2 !== rc1 + 1) begin n_bad++;
      $display("FAIL b2b_read: got ar edge %0d want %0d", ac2, rc1 + 1); end
    axi_write(BASE + 64'd88, 64'h11, 8'hFF, 0, 0, 0, l, mc1, bc1, st, hl, ra, ok);
    axi_write(BASE + 64'd96, 64'h22, 8'hFF, 0, 0, 0, l, mc2, bc2, st, hl, ra, ok);
    model_write(BASE + 64'd88, 64'h11, 8'hFF);
    model_write(BASE + 64'd96, 64'h22, 8'hFF);
    n_cmp++; if (mc2 !== bc1 + 1) begin n_bad++;
      $display("FAIL b2b_write: got capture edge %0d want %0d", mc2, bc1 + 1); end
  endtask

  task automatic test_random();
    int wl, mc, bc, rl, ac, rc; bit wst, hl, wok, rok, rst_st; logic [1:0] ra;
    logic [63:0] wa, rdaddr, wd, d, exp_r; logic [7:0] ws; int op, wi, ri;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      wd = {$urandom(), $urandom()};
      ws = 8'($urandom());
      if (op == 0) begin
        wa = rand_addr($urandom_range(0, 3) == 0);
        axi_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  wl, mc, bc, wst, hl, ra, wok);
        model_write(wa, wd, ws);
        n_cmp++; if (!wok || wl !== WR_LAT || !wst || ra !== 2'b11) begin n_bad++;
          $display("FAIL rnd_wr #%0d: got lat %0d stable %0b rdy %b want %0d 1 11", it, wl, wst, ra, WR_LAT); end
      end else if (op == 1) begin
        rdaddr = rand_addr($urandom_range(0, 3) == 0);
        exp_r = model_read(rdaddr);
        axi_read(rdaddr, $urandom_range(0, 3), $urandom_range(0, 3), d, rl, ac, rc, rst_st, rok);
        n_cmp++; if (!rok || d !== exp_r || rl !== RD_LAT || !rst_st) begin n_bad++;
          $display("FAIL rnd_rd #%0d: got %h lat %0d want %h lat %0d", it, d, rl, exp_r, RD_LAT); end
      end else begin
        wi = $urandom_range(0, 15);
        ri = (wi + $urandom_range(1, 15)) % 16;
        wa = BASE + 64'(wi) * 64'd8;
        rdaddr = BASE + 64'(ri) * 64'd8 + 64'($urandom_range(0, 7));
        exp_r = model_read(rdaddr);
        fork
          axi_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    wl, mc, bc, wst, hl, ra, wok);
          axi_read(rdaddr, $urandom_range(0, 3), $urandom_range(0, 3), d, rl, ac, rc, rst_st, rok);
        join
        model_write(wa, wd, ws);
        n_cmp++; if (!wok || !rok || d !== exp_r || wl !== WR_LAT || rl !== RD_LAT) begin n_bad++;
          $display("FAIL rnd_conc #%0d: got %h wl %0d rl %0d want %h", it, d, wl, rl, exp_r); end
      end
    end
    // sweep the whole region against the model
    for (int w = 0; w < 16; w++) begin
      rdaddr = BASE + 64'(w) * 64'd8;
      axi_read(rdaddr, 0, 0, d, rl, ac, rc, rst_st, rok);
      n_cmp++; if (d !== model_read(rdaddr)) begin n_bad++;
        $display("FAIL rnd_sweep w%0d: got %h want %h", w, d, model_read(rdaddr)); end
    end
  endtask

  task automatic test_reset_mid();
    bit fire; int rl, ac, rc; bit st, ok; logic [63:0] d, a;
    a = BASE + 64'd16;
    m.aw_addr = a; m.w_data = 64'hDEAD_DEAD_DEAD_DEAD; m.w_strb = 8'hFF; m.ar_addr = a;
    m.aw_valid = 1; m.w_valid = 1; m.ar_valid = 1;
    fire = m.aw_ready && m.w_ready && m.ar_ready;
    @(posedge clk); #1;
    m.aw_valid = 0; m.w_valid = 0; m.ar_valid = 0;
    n_cmp++; if (fire !== 1'b1) begin n_bad++;
      $display("FAIL rstmid_accept: got %0b want 1", fire); end
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({m.aw_ready, m.w_ready, m.ar_ready, m.b_valid, m.r_valid} !== 5'b0) begin n_bad++;
        $display("FAIL rstmid_during %0d: got %b want 00000", i,
                 {m.aw_ready, m.w_ready, m.ar_ready, m.b_valid, m.r_valid}); end
    end
    rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if ({m.aw_ready, m.w_ready, m.ar_ready} !== 3'b111) begin n_bad++;
      $display("FAIL rstmid_release: got %b want 111", {m.aw_ready, m.w_ready, m.ar_ready}); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({m.b_valid, m.r_valid} !== 2'b00) begin n_bad++;
        $display("FAIL rstmid_no_resp %0d: got %b want 00", i, {m.b_valid, m.r_valid}); end
      @(posedge clk); #1;
    end
    axi_read(a, 0, 0, d, rl, ac, rc, st, ok);
    n_cmp++; if (!ok || d !== model_read(a)) begin n_bad++;
      $display("FAIL rstmid_mem_intact: got %h want %h", d, model_read(a)); end
  endtask

  initial begin
    m.aw_addr = '0; m.aw_valid = 0; m.w_data = '0; m.w_strb = '0; m.w_valid = 0;
    m.b_ready = 0; m.ar_addr = '0; m.ar_valid = 0; m.r_ready = 0;
    test_reset();
    test_init();
    test_write_read();
    test_strobe_merge();
    test_skew_backpressure();
    test_concurrent_oor();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
